// File: rtl/seg7_debug_display.sv
// seg7_debug_display
// Multi-channel 7-segment debug display. Each channel keeps a shadow copy of
// its last strobed value; a single shared converter (double-dabble for
// decimal, direct nibble split for hex) services pending channels round-robin
// and writes the resulting segment patterns and overflow flag per channel.
module seg7_debug_display #(
  parameter int CHANNELS    = 3,
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 2,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic                         Clk_O,
  input  logic                         Reset,
  input  logic                         hex_mode,
  input  logic [CHANNELS*WIDTH-1:0]    ch_data,
  input  logic [CHANNELS-1:0]          ch_valid,
  output logic [CHANNELS*DIGITS*7-1:0] seg,
  output logic [CHANNELS-1:0]          overflow,
  output logic                         busy
);

  localparam int BCD_D = (WIDTH + 2) / 3;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SHIFT  = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  // Patterns stored in active-low form; polarity applied on the way out.
  localparam logic [6:0] BLANK_CODE = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [6:0] DASH_CODE  = (SEG_ACT_LOW != 0) ? 7'h3F : 7'h40;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] c;
    case (v)
      4'h0: c = 7'h40;  4'h1: c = 7'h79;  4'h2: c = 7'h24;  4'h3: c = 7'h30;
      4'h4: c = 7'h19;  4'h5: c = 7'h12;  4'h6: c = 7'h02;  4'h7: c = 7'h78;
      4'h8: c = 7'h00;  4'h9: c = 7'h10;  4'hA: c = 7'h08;  4'hB: c = 7'h03;
      4'hC: c = 7'h46;  4'hD: c = 7'h21;  4'hE: c = 7'h06;  default: c = 7'h0E;
    endcase
    return (SEG_ACT_LOW != 0) ? c : ~c;
  endfunction

  logic [1:0]                   state_reg;
  logic [CH_W-1:0]              sel_reg;
  logic [CH_W-1:0]              ptr_reg;
  logic [CNT_W-1:0]             cnt_reg;
  logic [4*BCD_D-1:0]           bcd_reg;
  logic [WIDTH-1:0]             bin_reg;
  logic                         hex_reg;
  logic [CHANNELS-1:0]          pending_reg;
  logic [CHANNELS-1:0][WIDTH-1:0] shadow_reg;

  logic [CH_W-1:0]              pick;
  logic                         found;
  logic [CH_W-1:0]              ptr_next;
  logic [4*BCD_D-1:0]           bcd_adj;
  logic [4*(BCD_D+DIGITS)-1:0]  ext_bcd;
  logic [4*DIGITS+WIDTH-1:0]    ext_bin;
  logic [DIGITS*7-1:0]          new_seg;
  logic                         new_ovf;

  assign busy = (state_reg != S_IDLE);

  // Round-robin pick: first pending channel at or after the pointer, wrapping.
  always_comb begin
    int idx;
    logic [CH_W-1:0] idx_c;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    idx_c = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx   = (int'(ptr_reg) + k) % CHANNELS;
      idx_c = CH_W'(idx);
      if (!found && pending_reg[idx_c]) begin
        found = 1'b1;
        pick  = idx_c;
      end
    end
    ptr_next = (pick == CH_W'(CHANNELS - 1)) ? '0 : pick + CH_W'(1);
  end

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  always_comb begin
    bcd_adj = bcd_reg;
    for (int n = 0; n < BCD_D; n++) begin
      if (bcd_reg[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_reg[4*n +: 4] + 4'd3;
    end
  end

  // Digit patterns and overflow for the channel being finished.
  always_comb begin
    ext_bcd = '0;
    ext_bcd[4*BCD_D-1:0] = bcd_reg;
    ext_bin = '0;
    ext_bin[WIDTH-1:0] = bin_reg;
    new_ovf = hex_reg ? |(ext_bin >> (4*DIGITS)) : |(ext_bcd >> (4*DIGITS));
    new_seg = '0;
    for (int d = 0; d < DIGITS; d++) begin
      new_seg[7*d +: 7] = new_ovf ? DASH_CODE
                        : glyph(hex_reg ? ext_bin[4*d +: 4] : ext_bcd[4*d +: 4]);
    end
  end

  // Capture, pending bookkeeping and conversion FSM.
  always_ff @(posedge Clk_O or negedge Reset) begin
    if (!Reset) begin
      state_reg   <= S_IDLE;
      sel_reg     <= '0;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      bcd_reg     <= '0;
      bin_reg     <= '0;
      hex_reg     <= 1'b0;
      pending_reg <= '0;
      shadow_reg  <= '0;
    end else begin
      // Clear first so a same-edge strobe below re-arms the channel.
      if (state_reg == S_LOAD) pending_reg[sel_reg] <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (ch_valid[i]) begin
          shadow_reg[i]  <= ch_data[i*WIDTH +: WIDTH];
          pending_reg[i] <= 1'b1;
        end
      end
      case (state_reg)
        S_IDLE: begin
          if (found) begin
            sel_reg   <= pick;
            ptr_reg   <= ptr_next;
            state_reg <= S_LOAD;
          end
        end
        S_LOAD: begin
          bin_reg   <= shadow_reg[sel_reg];
          bcd_reg   <= '0;
          cnt_reg   <= '0;
          hex_reg   <= hex_mode;
          state_reg <= hex_mode ? S_UPDATE : S_SHIFT;
        end
        S_SHIFT: begin
          {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH - 1)) state_reg <= S_UPDATE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [DIGITS*7-1:0] ch_seg_reg;
      logic                ch_ovf_reg;

      // Per-channel display latch, written only when this channel finishes.
      always_ff @(posedge Clk_O or negedge Reset) begin
        if (!Reset) begin
          ch_seg_reg <= {DIGITS{BLANK_CODE}};
          ch_ovf_reg <= 1'b0;
        end else if (state_reg == S_UPDATE && sel_reg == CH_W'(gi)) begin
          ch_seg_reg <= new_seg;
          ch_ovf_reg <= new_ovf;
        end
      end

      assign seg[gi*DIGITS*7 +: DIGITS*7] = ch_seg_reg;
      assign overflow[gi]                 = ch_ovf_reg;
    end
  endgenerate

endmodule
